// File: rtl/mem_arbiter_if.sv
// Bundle of both cache-side request ports and the off-chip memory port of mem_arbiter.
// slave = arbiter view; master = environment view (caches plus memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic              i_req_i;
    logic              i_write_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic [DATA_W-1:0] i_data_i;
    logic [DATA_W-1:0] i_data_o;
    logic              i_ack_o;

    logic              d_req_i;
    logic              d_write_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_data_i;
    logic [DATA_W-1:0] d_data_o;
    logic              d_ack_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic              busy_o;

    modport slave (
        input  i_req_i, i_write_i, i_addr_i, i_data_i,
        input  d_req_i, d_write_i, d_addr_i, d_data_i,
        input  mem_data_i, mem_ack_i,
        output i_data_o, i_ack_o, d_data_o, d_ack_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, busy_o
    );

    modport master (
        output i_req_i, i_write_i, i_addr_i, i_data_i,
        output d_req_i, d_write_i, d_addr_i, d_data_i,
        output mem_data_i, mem_ack_i,
        input  i_data_o, i_ack_o, d_data_o, d_ack_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, busy_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one off-chip line port between I$ and D$; one access in flight, grant held until mem ack,
// ack returned one cycle after mem ack. Ties go to D unless MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t            r_state;
    owner_t            r_owner;
    owner_t            r_last_grant;
    logic              r_mem_enable;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_i_data;
    logic [DATA_W-1:0] r_d_data;
    logic              r_busy;

    logic              w_any_req;
    logic              w_pick_d;

    // On a tie D wins, except in round-robin mode where the port not granted last time wins.
    assign w_any_req = bus.i_req_i || bus.d_req_i;
    assign w_pick_d  = bus.d_req_i && (!bus.i_req_i || !RR_EN || (r_last_grant == OWN_I));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_last_grant <= OWN_I;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_i_data     <= '0;
            r_d_data     <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_pick_d ? OWN_D : OWN_I;
                        r_mem_write  <= w_pick_d ? bus.d_write_i : bus.i_write_i;
                        r_mem_addr   <= w_pick_d ? bus.d_addr_i  : bus.i_addr_i;
                        r_mem_data   <= w_pick_d ? bus.d_data_i  : bus.i_data_i;
                        r_mem_enable <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Requester inputs are deliberately ignored here; the latched copy drives memory.
                    if (bus.mem_ack_i) begin
                        r_mem_enable <= 1'b0;
                        r_mem_write  <= 1'b0;
                        if (r_owner == OWN_D) begin
                            r_d_data <= bus.mem_data_i;
                            r_d_ack  <= 1'b1;
                        end else begin
                            r_i_data <= bus.mem_data_i;
                            r_i_ack  <= 1'b1;
                        end
                        r_last_grant <= r_owner;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // One dead cycle lets the owner drop req before IDLE samples again.
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_enable <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_i_ack      <= 1'b0;
                    r_d_ack      <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_enable_o = r_mem_enable;
    assign bus.mem_write_o  = r_mem_write;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_data_o   = r_mem_data;
    assign bus.i_ack_o      = r_i_ack;
    assign bus.d_ack_o      = r_d_ack;
    assign bus.i_data_o     = r_i_data;
    assign bus.d_data_o     = r_d_data;
    assign bus.busy_o       = r_busy;

endmodule
